control_sequencer: RTL and testbench

- Hardwired control unit that sequences the single-bus datapath through fetch and execute of register-to-register instructions.
- It drives the bus-source selects, register write strobes, register-file location, ALU opcode, PC-increment and MDR-source controls.
- It handshakes with memory during fetch, and runs continuously while enabled until a HALT, an illegal opcode or a memory fault.
- It sits between the IR output and the datapath control inputs, and replaces the hand-written state sequences in benches.

---
 rtl/control_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the single-bus datapath.
// Fetches through T0..T2 (memory handshake in T1) and executes register-to-register
// instructions in T3..T6. It runs while in_run is high and stops in HALT on a HALT
// opcode, an illegal opcode or a fetch timeout.
// Outputs are decoded combinationally from the state register and in_ir. The one
// exception is the mdr strobe in T1, which also follows in_mem_ready.
// Optional feature: define CTRL_INSTR_COUNT_EN to build the retired-instruction counter.
//   When the macro is undefined, out_instr_count is tied to zero.
// Ports:
//   clk, in_reset_n        clock (rising edge) and async active-low reset
//   in_run                 level enable for fetching / continuing
//   in_ir                  instruction register {op[31:27], Ra[26:23], Rb[22:19], Rc[18:15]}
//   in_mem_ready           memory read data valid during T1
//   out_read_sel           one-hot bus source {c,inport,mdr,pc,z_lo,z_hi,lo,hi,regfile}
//   out_write_en           strobes {mar,y,ir,mdr,pc,z,lo,hi,regfile}
//   out_regfile_location   register-file index
//   out_alu_opcode         ALU operation
//   out_inc_pc             PC loads PC+1
//   out_mdr_select         MDR source: 1 = memory, 0 = bus
//   out_reg_clear          datapath register clear
//   out_state              current state (debug)
//   out_halted             in HALT
//   out_illegal            sticky illegal-opcode flag
//   out_mem_fault          sticky fetch-timeout flag
//   out_instr_count        retired instruction count
module control_sequencer #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned CLEAR_CYCLES = 1
) (
   input  logic        clk,
   input  logic        in_reset_n,
   input  logic        in_run,
   input  logic [31:0] in_ir,
   input  logic        in_mem_ready,
   output logic [8:0]  out_read_sel,
   output logic [8:0]  out_write_en,
   output logic [3:0]  out_regfile_location,
   output logic [3:0]  out_alu_opcode,
   output logic        out_inc_pc,
   output logic        out_mdr_select,
   output logic        out_reg_clear,
   output logic [3:0]  out_state,
   output logic        out_halted,
   output logic        out_illegal,
   output logic        out_mem_fault,
   output logic [31:0] out_instr_count
);

   typedef enum logic [3:0] {
      S_CLR  = 4'd0,
      S_IDLE = 4'd1,
      S_T0   = 4'd2,
      S_T1   = 4'd3,
      S_T2   = 4'd4,
      S_T3   = 4'd5,
      S_T4   = 4'd6,
      S_T5   = 4'd7,
      S_T6   = 4'd8,
      S_HALT = 4'd9
   } state_t;

   // Bit positions inside out_read_sel
   localparam int RS_REGFILE = 0;
   localparam int RS_ZHI     = 3;
   localparam int RS_ZLO     = 4;
   localparam int RS_PC      = 5;
   localparam int RS_MDR     = 6;

   // Bit positions inside out_write_en
   localparam int WE_REGFILE = 0;
   localparam int WE_HI      = 1;
   localparam int WE_LO      = 2;
   localparam int WE_Z       = 3;
   localparam int WE_PC      = 4;
   localparam int WE_MDR     = 5;
   localparam int WE_IR      = 6;
   localparam int WE_Y       = 7;
   localparam int WE_MAR     = 8;

   // Terminal values of the down-counting windows
   localparam logic [7:0] WAIT_LAST  = 8'(MEM_WAIT_MAX - 1);
   localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] clr_cnt_q, clr_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       illegal_q, illegal_d;
   logic       mem_fault_q, mem_fault_d;

   // Instruction field decode
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_rtype, is_muldiv, is_unary, is_nop, is_halt;
   logic [3:0] alu_op;

   assign opcode = in_ir[31:27];
   assign ra     = in_ir[26:23];
   assign rb     = in_ir[22:19];
   assign rc     = in_ir[18:15];
   assign is_nop  = (opcode == 5'h1A);
   assign is_halt = (opcode == 5'h1B);

   always_comb begin
      is_rtype  = 1'b1;
      is_muldiv = 1'b0;
      is_unary  = 1'b0;
      alu_op    = 4'h0;
      case (opcode)
         5'h03: alu_op = 4'h0;                       // add
         5'h04: alu_op = 4'h1;                       // sub
         5'h05: alu_op = 4'h2;                       // shr
         5'h06: alu_op = 4'h3;                       // shl
         5'h07: alu_op = 4'h4;                       // ror
         5'h08: alu_op = 4'h5;                       // rol
         5'h09: alu_op = 4'h6;                       // and
         5'h0A: alu_op = 4'h7;                       // or
         5'h0E: begin alu_op = 4'h8; is_muldiv = 1'b1; end
         5'h0F: begin alu_op = 4'h9; is_muldiv = 1'b1; end
         5'h10: begin alu_op = 4'hA; is_unary  = 1'b1; end
         5'h11: begin alu_op = 4'hB; is_unary  = 1'b1; end
         default: is_rtype = 1'b0;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      illegal_d   = illegal_q;
      mem_fault_d = mem_fault_q;
      case (state_q)
         S_CLR: begin
            if (clr_cnt_q == CLEAR_LAST) begin
               state_d = S_IDLE;
            end else begin
               clr_cnt_d = clr_cnt_q + 4'd1;
            end
         end
         S_IDLE: begin
            if (in_run) state_d = S_T0;
         end
         S_T0: begin
            wait_cnt_d = 8'd0;
            state_d    = S_T1;
         end
         S_T1: begin
            if (in_mem_ready) begin
               state_d = S_T2;
            end else if (wait_cnt_q == WAIT_LAST) begin
               mem_fault_d = 1'b1;
               state_d     = S_HALT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_T2: state_d = S_T3;
         S_T3: begin
            if (is_rtype) begin
               state_d = S_T4;
            end else if (is_nop) begin
               state_d = in_run ? S_T0 : S_IDLE;
            end else if (is_halt) begin
               state_d = S_HALT;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_T4: state_d = S_T5;
         S_T5: begin
            if (is_muldiv) state_d = S_T6;
            else           state_d = in_run ? S_T0 : S_IDLE;
         end
         S_T6: state_d = in_run ? S_T0 : S_IDLE;
         S_HALT: state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q     <= S_CLR;
         clr_cnt_q   <= 4'd0;
         wait_cnt_q  <= 8'd0;
         illegal_q   <= 1'b0;
         mem_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         illegal_q   <= illegal_d;
         mem_fault_q <= mem_fault_d;
      end
   end

   // Control decode; every state drives at most one read-select bit
   always_comb begin
      out_read_sel         = 9'd0;
      out_write_en         = 9'd0;
      out_regfile_location = 4'd0;
      out_alu_opcode       = 4'd0;
      out_inc_pc           = 1'b0;
      out_mdr_select       = 1'b0;
      out_reg_clear        = 1'b0;
      out_halted           = 1'b0;
      case (state_q)
         S_CLR: out_reg_clear = 1'b1;
         S_T0: begin
            out_read_sel[RS_PC]  = 1'b1;
            out_write_en[WE_MAR] = 1'b1;
            out_write_en[WE_PC]  = 1'b1;
            out_inc_pc           = 1'b1;
         end
         S_T1: begin
            out_mdr_select       = 1'b1;
            out_write_en[WE_MDR] = in_mem_ready;
         end
         S_T2: begin
            out_read_sel[RS_MDR] = 1'b1;
            out_write_en[WE_IR]  = 1'b1;
         end
         S_T3: begin
            if (is_rtype) begin
               out_read_sel[RS_REGFILE] = 1'b1;
               out_write_en[WE_Y]       = 1'b1;
               out_regfile_location     = rb;
            end
         end
         S_T4: begin
            out_read_sel[RS_REGFILE] = 1'b1;
            out_write_en[WE_Z]       = 1'b1;
            out_alu_opcode           = alu_op;
            out_regfile_location     = is_unary ? rb : rc;
         end
         S_T5: begin
            out_read_sel[RS_ZLO] = 1'b1;
            if (is_muldiv) begin
               out_write_en[WE_LO] = 1'b1;
            end else begin
               out_write_en[WE_REGFILE] = 1'b1;
               out_regfile_location     = ra;
            end
         end
         S_T6: begin
            out_read_sel[RS_ZHI] = 1'b1;
            out_write_en[WE_HI]  = 1'b1;
         end
         S_HALT: out_halted = 1'b1;
         default: ;
      endcase
   end

   assign out_state     = state_q;
   assign out_illegal   = illegal_q;
   assign out_mem_fault = mem_fault_q;

`ifdef CTRL_INSTR_COUNT_EN
   // An instruction retires as the sequencer leaves its last execute state
   logic [31:0] instr_cnt_q;
   logic        retire;

   assign retire = ((state_q == S_T5) && !is_muldiv) ||
                   (state_q == S_T6) ||
                   ((state_q == S_T3) && is_nop);

   always_ff @(posedge clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         instr_cnt_q <= 32'd0;
      end else if (retire) begin
         instr_cnt_q <= instr_cnt_q + 32'd1;
      end
   end

   assign out_instr_count = instr_cnt_q;
`else
   assign out_instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: queues expected control vectors, checked each falling edge.
// Latency: one expected vector per clock cycle, compared half a cycle after the rising edge.
// Backpressure: memory ready is driven per cycle; stall cycles in T1 are modelled explicitly.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        in_reset_n;
    logic        in_run;
    logic [31:0] in_ir;
    logic        in_mem_ready;
    logic [8:0]  out_read_sel;
    logic [8:0]  out_write_en;
    logic [3:0]  out_regfile_location;
    logic [3:0]  out_alu_opcode;
    logic        out_inc_pc;
    logic        out_mdr_select;
    logic        out_reg_clear;
    logic [3:0]  out_state;
    logic        out_halted;
    logic        out_illegal;
    logic        out_mem_fault;
    logic [31:0] out_instr_count;

    control_sequencer #(.MEM_WAIT_MAX(15), .CLEAR_CYCLES(1)) dut (
        .clk                  (clk),
        .in_reset_n           (in_reset_n),
        .in_run               (in_run),
        .in_ir                (in_ir),
        .in_mem_ready         (in_mem_ready),
        .out_read_sel         (out_read_sel),
        .out_write_en         (out_write_en),
        .out_regfile_location (out_regfile_location),
        .out_alu_opcode       (out_alu_opcode),
        .out_inc_pc           (out_inc_pc),
        .out_mdr_select       (out_mdr_select),
        .out_reg_clear        (out_reg_clear),
        .out_state            (out_state),
        .out_halted           (out_halted),
        .out_illegal          (out_illegal),
        .out_mem_fault        (out_mem_fault),
        .out_instr_count      (out_instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] RS_RF  = 9'h001, RS_ZHI = 9'h008, RS_ZLO = 9'h010;
    localparam logic [8:0] RS_PC  = 9'h020, RS_MDR = 9'h040;
    localparam logic [8:0] WE_RF  = 9'h001, WE_HI  = 9'h002, WE_LO  = 9'h004;
    localparam logic [8:0] WE_Z   = 9'h008, WE_MDR = 9'h020, WE_IR  = 9'h040;
    localparam logic [8:0] WE_Y   = 9'h080, WE_T0  = 9'h110;
    localparam logic [5:0] M_INC  = 6'b100000, M_MSEL = 6'b010000, M_CLR = 6'b001000;
    localparam logic [5:0] M_HALT = 6'b000100, M_ILL  = 6'b000010, M_FLT = 6'b000001;

    typedef struct packed {
        logic [3:0]  st;
        logic [8:0]  rs;
        logic [8:0]  we;
        logic [3:0]  loc;
        logic [3:0]  alu;
        logic [5:0]  misc;
        logic [31:0] cnt;
        logic        clr_dc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic logic [31:0] cntv(input int n);
`ifdef CTRL_INSTR_COUNT_EN
        return 32'(n);
`else
        return 32'd0 & 32'(n);
`endif
    endfunction

    task automatic cyc(input string nm, input logic [3:0] st, input logic [8:0] rs,
                       input logic [8:0] we, input logic [3:0] loc, input logic [3:0] alu,
                       input logic [5:0] misc, input int n);
        exp_t e;
        e.st = st; e.rs = rs; e.we = we; e.loc = loc; e.alu = alu;
        e.misc = misc; e.cnt = cntv(n); e.clr_dc = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic rst_cyc(input string nm);
        exp_t e;
        e = '0;
        e.clr_dc = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [31:0] ir, input int wait_n, input int n);
        in_ir = ir;
        cyc("t0", 4'd2, RS_PC, WE_T0, 4'd0, 4'd0, M_INC, n);
        in_mem_ready = 1'b0;
        for (int i = 0; i < wait_n; i++)
            cyc("t1_wait", 4'd3, 9'd0, 9'd0, 4'd0, 4'd0, M_MSEL, n);
        in_mem_ready = 1'b1;
        cyc("t1_ready", 4'd3, 9'd0, WE_MDR, 4'd0, 4'd0, M_MSEL, n);
        in_mem_ready = 1'b0;
        cyc("t2", 4'd4, RS_MDR, WE_IR, 4'd0, 4'd0, 6'd0, n);
    endtask

    task automatic rtype(input logic [31:0] ir, input int wait_n, input logic [3:0] l3,
                         input logic [3:0] l4, input logic [3:0] l5, input logic [3:0] alu,
                         input bit muldiv, input int n, input bit drop_run);
        fetch(ir, wait_n, n);
        cyc("t3", 4'd5, RS_RF, WE_Y, l3, 4'd0, 6'd0, n);
        if (drop_run) in_run = 1'b0;
        cyc("t4", 4'd6, RS_RF, WE_Z, l4, alu, 6'd0, n);
        if (muldiv) begin
            cyc("t5_lo", 4'd7, RS_ZLO, WE_LO, 4'd0, 4'd0, 6'd0, n);
            cyc("t6_hi", 4'd8, RS_ZHI, WE_HI, 4'd0, 4'd0, 6'd0, n);
        end else begin
            cyc("t5_wb", 4'd7, RS_ZLO, WE_RF, l5, 4'd0, 6'd0, n);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, got, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.st = out_state; a.rs = out_read_sel; a.we = out_write_en;
            a.loc = out_regfile_location; a.alu = out_alu_opcode;
            a.misc = {out_inc_pc, out_mdr_select, out_reg_clear, out_halted,
                      out_illegal, out_mem_fault};
            a.cnt = out_instr_count; a.clr_dc = e.clr_dc;
            if (e.clr_dc) a.misc[3] = e.misc[3];
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: got st=%0d rs=%h we=%h loc=%0d alu=%0d misc=%b cnt=%0d, expected st=%0d rs=%h we=%h loc=%0d alu=%0d misc=%b cnt=%0d",
                         nm, $time, a.st, a.rs, a.we, a.loc, a.alu, a.misc, a.cnt,
                         e.st, e.rs, e.we, e.loc, e.alu, e.misc, e.cnt);
            end
        end
    end

    always @(negedge clk) begin
        if (in_reset_n === 1'b1) begin
            n_checks++;
            if ((out_read_sel & (out_read_sel - 9'd1)) !== 9'd0) begin
                n_fail++;
                $display("FAIL onehot @%0t: read_sel=%h", $time, out_read_sel);
            end
        end
    end

    initial begin
        in_reset_n = 1'b0; in_run = 1'b1; in_ir = 32'd0; in_mem_ready = 1'b0;
        @(posedge clk); #1;
        rst_cyc("reset0");
        rst_cyc("reset1");
        in_reset_n = 1'b1;
        cyc("clr", 4'd0, 9'd0, 9'd0, 4'd0, 4'd0, M_CLR, 0);
        cyc("idle", 4'd1, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 0);

        rtype(32'h4A920000, 0, 4'd2, 4'd4, 4'd5, 4'h6, 1'b0, 0, 1'b0);
        rtype(32'h48B98000, 2, 4'd7, 4'd3, 4'd1, 4'h6, 1'b0, 1, 1'b0);
        rtype(32'h71200000, 0, 4'd4, 4'd0, 4'd0, 4'h8, 1'b1, 2, 1'b0);
        rtype(32'h809B8000, 1, 4'd3, 4'd3, 4'd1, 4'hA, 1'b0, 3, 1'b0);
        rtype(32'h4A920000, 0, 4'd2, 4'd4, 4'd5, 4'h6, 1'b0, 4, 1'b1);
        cyc("idle_norun", 4'd1, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 5);
        check_bit("idle_after_drop", out_state == 4'd1, 1'b1);
        in_run = 1'b1;
        cyc("idle_run", 4'd1, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 5);

        fetch(32'hD0000000, 0, 5);
        in_run = 1'b0;
        cyc("nop_t3", 4'd5, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 5);
        cyc("idle_after_nop", 4'd1, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 6);
        in_run = 1'b1;
        cyc("idle_run2", 4'd1, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 6);

        fetch(32'hD8000000, 0, 6);
        cyc("halt_t3", 4'd5, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 6);
        cyc("halt0", 4'd9, 9'd0, 9'd0, 4'd0, 4'd0, M_HALT, 6);
        cyc("halt1", 4'd9, 9'd0, 9'd0, 4'd0, 4'd0, M_HALT, 6);
        check_bit("halt_halted", out_halted, 1'b1);
        check_bit("halt_not_illegal", out_illegal, 1'b0);

        in_reset_n = 1'b0;
        rst_cyc("reset_mid");
        in_reset_n = 1'b1;
        cyc("clr2", 4'd0, 9'd0, 9'd0, 4'd0, 4'd0, M_CLR, 0);
        cyc("idle4", 4'd1, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 0);
        fetch(32'hF8000000, 0, 0);
        cyc("ill_t3", 4'd5, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 0);
        cyc("ill_halt0", 4'd9, 9'd0, 9'd0, 4'd0, 4'd0, M_HALT | M_ILL, 0);
        cyc("ill_halt1", 4'd9, 9'd0, 9'd0, 4'd0, 4'd0, M_HALT | M_ILL, 0);
        check_bit("ill_flag", out_illegal, 1'b1);

        in_reset_n = 1'b0;
        rst_cyc("reset_clears_ill");
        in_reset_n = 1'b1;
        check_bit("ill_cleared", out_illegal, 1'b0);
        cyc("clr3", 4'd0, 9'd0, 9'd0, 4'd0, 4'd0, M_CLR, 0);
        cyc("idle5", 4'd1, 9'd0, 9'd0, 4'd0, 4'd0, 6'd0, 0);
        in_ir = 32'h4A920000; in_mem_ready = 1'b0;
        cyc("flt_t0", 4'd2, RS_PC, WE_T0, 4'd0, 4'd0, M_INC, 0);
        for (int i = 0; i < 15; i++) begin
            check_bit("flt_no_mdr_we", out_write_en[5], 1'b0);
            cyc("flt_t1", 4'd3, 9'd0, 9'd0, 4'd0, 4'd0, M_MSEL, 0);
        end
        cyc("flt_halt0", 4'd9, 9'd0, 9'd0, 4'd0, 4'd0, M_HALT | M_FLT, 0);
        cyc("flt_halt1", 4'd9, 9'd0, 9'd0, 4'd0, 4'd0, M_HALT | M_FLT, 0);
        check_bit("flt_flag", out_mem_fault, 1'b1);
        check_bit("flt_halted", out_halted, 1'b1);

        in_reset_n = 1'b0;
        rst_cyc("reset_clears_flt");
        in_reset_n = 1'b1;
        check_bit("flt_cleared", out_mem_fault, 1'b0);
        cyc("clr4", 4'd0, 9'd0, 9'd0, 4'd0, 4'd0, M_CLR, 0);

        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, limit 50000", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
